mic1_ws_core: RTL and testbench
===============================

# mic1_ws_core

Parametrised Mic-1 microarchitecture core with wait-state memory handshakes, the successor to the fixed one-cycle-memory Mic-1 datapath. It executes one 9-bus-field microinstruction per cycle from an external combinational microstore. Data-word and instruction-byte accesses use req/ack handshakes, and the core freezes whenever a result is needed before memory has answered. Optional performance counters are compiled in by macro.

## Interface
- DATA_W, 32: register, ALU and bus width (>= 16)
- MPC_W, 9: microaddress width; MIR_W = MPC_W + 27
- CPP_RESET, 0: reset value of CPP
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- mp_addr  out  MPC_W  microstore address (= MPC register)
- mp_rdata  in  MIR_W  microinstruction, combinational from mp_addr
- dmem_req / dmem_we  out  1  data request / write qualifier
- dmem_addr / dmem_wdata  out  DATA_W  captured word address / write data
- dmem_rdata  in  DATA_W  read data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion pulse
- imem_req  out  1  byte-fetch request
- imem_addr  out  DATA_W  captured PC
- imem_rdata  in  8  fetched byte, valid with imem_ack
- imem_ack  in  1  one-cycle completion pulse
- stall  out  1  current microinstruction held this cycle
- out  out  DATA_W  H register (debug)
- cyc_cnt, stall_cnt  out  32  performance counters (see Configuration)

## Operation
- MIR fields: B_sel[3:0], mem[6:4] (wr, rd, fetch), C_sel[15:7] (MAR,MDR,PC,SP,LV,CPP,TOS,OPC,H from bit 7 up), ALU[21:16] (F0,F1,ENA,ENB,INVA,INC), shift[23:22] (SLL8, SRA1), jump[26:24] (JMPC, JAMN, JAMZ), next[MIR_W-1:27].
- B bus: 0 MDR, 1 PC, 2 MBR sign-extended, 3 MBR zero-extended, 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC, 9–15 zero. A input is H.
- ALU: standard Mic-1 functions, modulo 2^DATA_W. N = result MSB, Z = result == 0, taken pre-shift. Shift: SLL8 left 8 zero-fill, SRA1 arithmetic right 1. Both set: SLL8 only.
- C written to every register selected in C_sel at commit.
- Next MPC: JMPC gives next | zero-extended MBR. Otherwise next with bit MPC_W-1 ORed by (JAMZ&Z)|(JAMN&N), using this cycle's ALU flags.
- Memory issue at commit of a microinstruction with mem ≠ 0:
  - dmem_addr gets the post-commit MAR, dmem_wdata the post-commit MDR, imem_addr the post-commit PC.
  - req is raised next cycle. wr and rd both set: write only.
- req stays high through the ack cycle and drops the cycle after. Read ack loads MDR from dmem_rdata, and fetch ack loads MBR from imem_rdata, at that same edge. A memory load overrides a same-edge C write.
- State per port: IDLE → PEND (issue) → IDLE (ack).
- stall = (data PEND & ~dmem_ack) | (inst PEND & ~imem_ack).
- While stalled: no register, flag or MPC update, no new issue, mem fields ignored.
- Acks while IDLE are ignored.

## Timing
- Reset values: all outputs 0, except imem_addr = all-ones and the PC register = all-ones. MPC = 0, MAR..H = 0, CPP = CPP_RESET, MBR = 0.
- Zero-wait memory (ack in first req cycle) matches classic Mic-1: data usable by microinstruction k+2 after issuer k, with no stall.
- Each extra wait cycle stalls microinstruction k+1 exactly one cycle.
- Data and fetch may be pending together; k+1 commits in the cycle the later ack arrives.
- Reset mid-request drops req in the same cycle, combinationally from reset. A late ack after reset is ignored.

## Configuration
- MIC1_PERF_EN defined:
  - cyc_cnt increments every cycle out of reset.
  - stall_cnt increments every stall cycle.
  - Both wrap at 2^32 and reset to 0.
- MIC1_PERF_EN undefined: both ports tied 0 and no counter flops exist.

## Test plan
- Reset, then microinstruction H=H+1 (ALU 111101? no: ENB=0 INC A+1, C_sel H) run 3 times → out = 3, stall never high.
- MAR=1; rd issued with ack delayed 2 cycles and rdata 0xDEADBEEF → stall high 2 cycles; MDR = 0xDEADBEEF at k+1 commit; stall_cnt = 2.
- PC=PC+1; fetch with imem_rdata 0x10; next microinstruction has JMPC, next = 0 → MPC = 0x010, imem_addr = 0.
- TOS=-1 through ALU with JAMN, next = 0x005 → MPC = 0x105. Same with Z: result 0, JAMZ → 0x105.
- wr and rd both set, MDR = 0x55 → dmem_we = 1, dmem_wdata = 0x55, MDR unchanged after ack.
- reset asserted while dmem_req high and no ack → req low the same cycle; an ack pulse after release causes no MDR change.

Source files
------------

// File: rtl/mic1_ws_core.sv
// mic1_ws_core: Mic-1 microarchitecture core with req/ack wait-state memory ports.
// Executes one microinstruction per cycle from an external combinational microstore
// and freezes when a result is needed before memory has answered.
//
// Optional feature macro: MIC1_PERF_EN (adds cycle and stall performance counters;
// when undefined both counter ports are tied to zero and no counter flops exist).
//
// Ports:
//   clk_i          clock, all state on the rising edge
//   reset_i        asynchronous active-high reset
//   mp_addr_o      microstore address (MPC register)
//   mp_rdata_i     microinstruction, combinational from mp_addr_o
//   dmem_req_o     data request, held until the ack cycle
//   dmem_we_o      data write qualifier
//   dmem_addr_o    captured word address (MAR)
//   dmem_wdata_o   captured write data (MDR)
//   dmem_rdata_i   read data, valid with dmem_ack_i
//   dmem_ack_i     one-cycle data completion pulse
//   imem_req_o     instruction byte fetch request
//   imem_addr_o    captured PC
//   imem_rdata_i   fetched byte, valid with imem_ack_i
//   imem_ack_i     one-cycle fetch completion pulse
//   stall_o        current microinstruction is held this cycle (combinational)
//   out_o          H register, for debug
//   cyc_cnt_o      cycles since reset (MIC1_PERF_EN)
//   stall_cnt_o    stalled cycles since reset (MIC1_PERF_EN)
module mic1_ws_core #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       MPC_W     = 9,
    parameter logic [DATA_W-1:0] CPP_RESET = '0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    output logic [MPC_W-1:0]    mp_addr_o,
    input  logic [MPC_W+26:0]   mp_rdata_i,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [DATA_W-1:0]   dmem_addr_o,
    output logic [DATA_W-1:0]   dmem_wdata_o,
    input  logic [DATA_W-1:0]   dmem_rdata_i,
    input  logic                dmem_ack_i,
    output logic                imem_req_o,
    output logic [DATA_W-1:0]   imem_addr_o,
    input  logic [7:0]          imem_rdata_i,
    input  logic                imem_ack_i,
    output logic                stall_o,
    output logic [DATA_W-1:0]   out_o,
    output logic [31:0]         cyc_cnt_o,
    output logic [31:0]         stall_cnt_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } port_st_t;

    // Microinstruction fields
    logic [3:0]       b_sel;
    logic             mem_fetch, mem_rd, mem_wr;
    logic [8:0]       c_sel;
    logic             f0, f1, ena, enb, inva, inc;
    logic             sll8, sra1;
    logic             jamz, jamn, jmpc;
    logic [MPC_W-1:0] next_addr;

    assign b_sel     = mp_rdata_i[3:0];
    assign mem_fetch = mp_rdata_i[4];
    assign mem_rd    = mp_rdata_i[5];
    assign mem_wr    = mp_rdata_i[6];
    assign c_sel     = mp_rdata_i[15:7];
    assign inc       = mp_rdata_i[16];
    assign inva      = mp_rdata_i[17];
    assign enb       = mp_rdata_i[18];
    assign ena       = mp_rdata_i[19];
    assign f1        = mp_rdata_i[20];
    assign f0        = mp_rdata_i[21];
    assign sra1      = mp_rdata_i[22];
    assign sll8      = mp_rdata_i[23];
    assign jamz      = mp_rdata_i[24];
    assign jamn      = mp_rdata_i[25];
    assign jmpc      = mp_rdata_i[26];
    assign next_addr = mp_rdata_i[MPC_W+26:27];

    // Architectural registers
    logic [DATA_W-1:0] mar_q, mdr_q, pc_q, sp_q, lv_q, cpp_q, tos_q, opc_q, h_q;
    logic [DATA_W-1:0] mar_d, mdr_d, pc_d, sp_d, lv_d, cpp_d, tos_d, opc_d, h_d;
    logic [7:0]        mbr_q, mbr_d;
    logic [MPC_W-1:0]  mpc_q, mpc_d;

    // Memory port state and captured request attributes
    port_st_t          d_st_q, d_st_d, i_st_q, i_st_d;
    logic              dmem_we_q, dmem_we_d;
    logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [DATA_W-1:0] imem_addr_q, imem_addr_d;

    logic [DATA_W-1:0] b_bus, a_op, b_op, alu_res, c_bus;
    logic              flag_n, flag_z;
    logic [MPC_W-1:0]  next_mpc;
    logic              stall, commit, issue;
    logic              d_ack_ok, i_ack_ok;

    // Acks only count while the port is waiting
    assign d_ack_ok = (d_st_q == ST_PEND) & dmem_ack_i;
    assign i_ack_ok = (i_st_q == ST_PEND) & imem_ack_i;

    assign stall  = ((d_st_q == ST_PEND) & ~dmem_ack_i) |
                    ((i_st_q == ST_PEND) & ~imem_ack_i);
    assign commit = ~stall;
    assign issue  = commit & (mem_wr | mem_rd | mem_fetch);

    // B bus source select
    always_comb begin
        b_bus = '0;
        case (b_sel)
            4'd0:    b_bus = mdr_q;
            4'd1:    b_bus = pc_q;
            4'd2:    b_bus = {{(DATA_W-8){mbr_q[7]}}, mbr_q};
            4'd3:    b_bus = {{(DATA_W-8){1'b0}}, mbr_q};
            4'd4:    b_bus = sp_q;
            4'd5:    b_bus = lv_q;
            4'd6:    b_bus = cpp_q;
            4'd7:    b_bus = tos_q;
            4'd8:    b_bus = opc_q;
            default: b_bus = '0;
        endcase
    end

    // ALU and shifter; flags come from the pre-shift result
    always_comb begin
        a_op    = ena ? h_q : '0;
        if (inva) begin
            a_op = ~a_op;
        end
        b_op    = enb ? b_bus : '0;
        alu_res = '0;
        case ({f0, f1})
            2'b00:   alu_res = a_op & b_op;
            2'b01:   alu_res = a_op | b_op;
            2'b10:   alu_res = ~b_op;
            default: alu_res = a_op + b_op + DATA_W'(inc);
        endcase
        flag_n = alu_res[DATA_W-1];
        flag_z = (alu_res == '0);
        c_bus  = alu_res;
        if (sll8) begin
            c_bus = {alu_res[DATA_W-9:0], 8'h00};
        end else if (sra1) begin
            c_bus = {alu_res[DATA_W-1], alu_res[DATA_W-1:1]};
        end
    end

    // Next microaddress: JMPC dispatch or JAM into the top address bit
    always_comb begin
        next_mpc = next_addr;
        if (jmpc) begin
            next_mpc = next_addr | MPC_W'(mbr_q);
        end else begin
            next_mpc[MPC_W-1] = next_addr[MPC_W-1] | (jamz & flag_z) | (jamn & flag_n);
        end
    end

    // Next-state: C writes on commit, memory loads win over a same-edge C write
    always_comb begin
        mar_d = mar_q;
        mdr_d = mdr_q;
        pc_d  = pc_q;
        sp_d  = sp_q;
        lv_d  = lv_q;
        cpp_d = cpp_q;
        tos_d = tos_q;
        opc_d = opc_q;
        h_d   = h_q;
        mbr_d = mbr_q;
        mpc_d = mpc_q;

        if (commit) begin
            if (c_sel[0]) mar_d = c_bus;
            if (c_sel[1]) mdr_d = c_bus;
            if (c_sel[2]) pc_d  = c_bus;
            if (c_sel[3]) sp_d  = c_bus;
            if (c_sel[4]) lv_d  = c_bus;
            if (c_sel[5]) cpp_d = c_bus;
            if (c_sel[6]) tos_d = c_bus;
            if (c_sel[7]) opc_d = c_bus;
            if (c_sel[8]) h_d   = c_bus;
            mpc_d = next_mpc;
        end

        if (d_ack_ok && !dmem_we_q) begin
            mdr_d = dmem_rdata_i;
        end
        if (i_ack_ok) begin
            mbr_d = imem_rdata_i;
        end
    end

    // Port FSMs and request capture; write wins when wr and rd are both set
    always_comb begin
        d_st_d       = d_st_q;
        i_st_d       = i_st_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        imem_addr_d  = imem_addr_q;

        if (d_ack_ok) d_st_d = ST_IDLE;
        if (i_ack_ok) i_st_d = ST_IDLE;

        if (issue) begin
            dmem_addr_d  = mar_d;
            dmem_wdata_d = mdr_d;
            imem_addr_d  = pc_d;
            dmem_we_d    = mem_wr;
            if (mem_wr || mem_rd) d_st_d = ST_PEND;
            if (mem_fetch)        i_st_d = ST_PEND;
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mar_q        <= '0;
            mdr_q        <= '0;
            pc_q         <= '1;
            sp_q         <= '0;
            lv_q         <= '0;
            cpp_q        <= CPP_RESET;
            tos_q        <= '0;
            opc_q        <= '0;
            h_q          <= '0;
            mbr_q        <= '0;
            mpc_q        <= '0;
            d_st_q       <= ST_IDLE;
            i_st_q       <= ST_IDLE;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            imem_addr_q  <= '1;
        end else begin
            mar_q        <= mar_d;
            mdr_q        <= mdr_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            lv_q         <= lv_d;
            cpp_q        <= cpp_d;
            tos_q        <= tos_d;
            opc_q        <= opc_d;
            h_q          <= h_d;
            mbr_q        <= mbr_d;
            mpc_q        <= mpc_d;
            d_st_q       <= d_st_d;
            i_st_q       <= i_st_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            imem_addr_q  <= imem_addr_d;
        end
    end

    assign mp_addr_o    = mpc_q;
    assign dmem_req_o   = (d_st_q == ST_PEND);
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign imem_req_o   = (i_st_q == ST_PEND);
    assign imem_addr_o  = imem_addr_q;
    assign stall_o      = stall;
    assign out_o        = h_q;

`ifdef MIC1_PERF_EN
    logic [31:0] cyc_cnt_q, stall_cnt_q;

    // Free-running performance counters, wrap at 2^32
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cyc_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign cyc_cnt_o   = cyc_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign cyc_cnt_o   = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mic1_ws_core.sv
// Directed self-checking bench for mic1_ws_core: the bench plays microstore and
// both memories, stepping one microinstruction at a time.
module tb_mic1_ws_core;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MPC_W  = 9;

`ifdef MIC1_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] ALU_A    = 6'b011000;
    localparam logic [5:0] ALU_B    = 6'b010100;
    localparam logic [5:0] ALU_A1   = 6'b111001;
    localparam logic [5:0] ALU_BP1  = 6'b110101;
    localparam logic [5:0] ALU_ZERO = 6'b010000;
    localparam logic [5:0] ALU_ONE  = 6'b110001;
    localparam logic [5:0] ALU_NEG1 = 6'b110010;

    localparam logic [8:0] C_NONE = 9'h000;
    localparam logic [8:0] C_MAR  = 9'h001;
    localparam logic [8:0] C_PC   = 9'h004;
    localparam logic [8:0] C_TOS  = 9'h040;
    localparam logic [8:0] C_H    = 9'h100;

    localparam logic [2:0] M_NONE  = 3'b000;
    localparam logic [2:0] M_WR    = 3'b100;
    localparam logic [2:0] M_RD    = 3'b010;
    localparam logic [2:0] M_FETCH = 3'b001;

    localparam logic [2:0] J_NONE = 3'b000;
    localparam logic [2:0] J_JMPC = 3'b100;
    localparam logic [2:0] J_JAMN = 3'b010;
    localparam logic [2:0] J_JAMZ = 3'b001;

    localparam logic [3:0] B_MDR = 4'd0;
    localparam logic [3:0] B_PC  = 4'd1;
    localparam logic [3:0] B_MBS = 4'd2;
    localparam logic [3:0] B_MBZ = 4'd3;
    localparam logic [3:0] B_TOS = 4'd7;

    logic                clk;
    logic                reset;
    logic [MPC_W-1:0]    mp_addr;
    logic [MPC_W+26:0]   mir;
    logic                dmem_req, dmem_we;
    logic [DATA_W-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
    logic                dmem_ack;
    logic                imem_req;
    logic [DATA_W-1:0]   imem_addr;
    logic [7:0]          imem_rdata;
    logic                imem_ack;
    logic                stall;
    logic [DATA_W-1:0]   out;
    logic [31:0]         cyc_cnt, stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cycles = 0;

    mic1_ws_core #(
        .DATA_W    (DATA_W),
        .MPC_W     (MPC_W),
        .CPP_RESET ('0)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .mp_addr_o    (mp_addr),
        .mp_rdata_i   (mir),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_rdata_i (dmem_rdata),
        .dmem_ack_i   (dmem_ack),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (imem_rdata),
        .imem_ack_i   (imem_ack),
        .stall_o      (stall),
        .out_o        (out),
        .cyc_cnt_o    (cyc_cnt),
        .stall_cnt_o  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] mk(input logic [8:0] nxt, input logic [2:0] jmp,
                                       input logic [1:0] sh, input logic [5:0] alu,
                                       input logic [8:0] c, input logic [2:0] mem,
                                       input logic [3:0] b);
        return {nxt, jmp, sh, alu, c, mem, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    localparam logic [35:0] NOP = 36'h0_0001_0000;

    initial begin
        reset      = 1'b1;
        mir        = NOP;
        dmem_rdata = '0;
        dmem_ack   = 1'b0;
        imem_rdata = '0;
        imem_ack   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_mp_addr", 64'(mp_addr), 64'h0);
        chk("rst_out", 64'(out), 64'h0);
        chk("rst_imem_addr", 64'(imem_addr), 64'hFFFF_FFFF);
        chk("rst_dmem_req", 64'(dmem_req), 64'h0);
        chk("rst_imem_req", 64'(imem_req), 64'h0);
        chk("rst_dmem_addr", 64'(dmem_addr), 64'h0);
        chk("rst_cyc_cnt", 64'(cyc_cnt), 64'h0);
        reset  = 1'b0;
        cycles = 0;

        // H = H + 1 three times, no memory, never stalls
        mir = mk(9'h0, J_NONE, 2'b00, ALU_A1, C_H, M_NONE, 4'd0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("inc_stall", 64'(stall), 64'h0);
            tick();
        end
        chk("inc_out", 64'(out), 64'h3);

        // MAR = 1, read with two wait cycles
        mir = mk(9'h0, J_NONE, 2'b00, ALU_ONE, C_MAR, M_NONE, 4'd0);
        tick();
        mir = mk(9'h0, J_NONE, 2'b00, ALU_ZERO, C_NONE, M_RD, 4'd0);
        tick();
        chk("rd_req", 64'(dmem_req), 64'h1);
        chk("rd_addr", 64'(dmem_addr), 64'h1);
        chk("rd_we", 64'(dmem_we), 64'h0);
        mir = mk(9'h0, J_NONE, 2'b00, ALU_A1, C_H, M_NONE, 4'd0);
        #1 chk("rd_stall_w1", 64'(stall), 64'h1);
        tick();
        #1 chk("rd_stall_w2", 64'(stall), 64'h1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1 chk("rd_stall_ack", 64'(stall), 64'h0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        chk("rd_k1_once", 64'(out), 64'h4);
        chk("rd_req_drop", 64'(dmem_req), 64'h0);
        mir = mk(9'h0, J_NONE, 2'b00, ALU_B, C_H, M_NONE, B_MDR);
        tick();
        chk("rd_mdr", 64'(out), 64'hDEAD_BEEF);
        chk("stall_cnt", 64'(stall_cnt), PERF ? 64'h2 : 64'h0);
        chk("cyc_cnt", 64'(cyc_cnt), PERF ? 64'(cycles) : 64'h0);

        // PC = PC + 1 with zero-wait fetch of 0x10, then dispatch
        mir = mk(9'h0, J_NONE, 2'b00, ALU_BP1, C_PC, M_FETCH, B_PC);
        tick();
        chk("fetch_req", 64'(imem_req), 64'h1);
        chk("fetch_addr", 64'(imem_addr), 64'h0);
        mir        = NOP;
        imem_ack   = 1'b1;
        imem_rdata = 8'h10;
        #1 chk("fetch_nostall", 64'(stall), 64'h0);
        tick();
        imem_ack = 1'b0;
        chk("fetch_req_drop", 64'(imem_req), 64'h0);
        mir = mk(9'h0, J_JMPC, 2'b00, ALU_ZERO, C_NONE, M_NONE, 4'd0);
        tick();
        chk("jmpc_mpc", 64'(mp_addr), 64'h010);

        // JAMN / JAMZ
        mir = mk(9'h005, J_JAMN, 2'b00, ALU_NEG1, C_TOS, M_NONE, 4'd0);
        tick();
        chk("jamn_mpc", 64'(mp_addr), 64'h105);
        mir = mk(9'h005, J_JAMZ, 2'b00, ALU_ZERO, C_NONE, M_NONE, 4'd0);
        tick();
        chk("jamz_mpc", 64'(mp_addr), 64'h105);
        mir = mk(9'h005, J_JAMZ, 2'b00, ALU_NEG1, C_NONE, M_NONE, 4'd0);
        tick();
        chk("jamz_nz_mpc", 64'(mp_addr), 64'h005);
        mir = mk(9'h0, J_NONE, 2'b00, ALU_B, C_H, M_NONE, B_TOS);
        tick();
        chk("tos_neg1", 64'(out), 64'hFFFF_FFFF);

        // Shifter: both bits means SLL8 only; SRA1 is arithmetic
        mir = mk(9'h0, J_NONE, 2'b11, ALU_ONE, C_H, M_NONE, 4'd0);
        tick();
        chk("sh_both", 64'(out), 64'h100);
        mir = mk(9'h0, J_NONE, 2'b10, ALU_NEG1, C_H, M_NONE, 4'd0);
        tick();
        chk("sh_sll8", 64'(out), 64'hFFFF_FF00);
        mir = mk(9'h0, J_NONE, 2'b01, ALU_A, C_H, M_NONE, 4'd0);
        tick();
        chk("sh_sra1", 64'(out), 64'hFFFF_FF80);

        // MDR = 0x55 by zero-wait read, then wr+rd is a write
        mir = mk(9'h0, J_NONE, 2'b00, ALU_ZERO, C_NONE, M_RD, 4'd0);
        tick();
        mir        = NOP;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55;
        tick();
        dmem_ack = 1'b0;
        mir = mk(9'h0, J_NONE, 2'b00, ALU_ZERO, C_NONE, M_WR | M_RD, 4'd0);
        tick();
        chk("wr_we", 64'(dmem_we), 64'h1);
        chk("wr_wdata", 64'(dmem_wdata), 64'h55);
        chk("wr_req", 64'(dmem_req), 64'h1);
        mir        = NOP;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h99;
        tick();
        dmem_ack = 1'b0;
        mir = mk(9'h0, J_NONE, 2'b00, ALU_B, C_H, M_NONE, B_MDR);
        tick();
        chk("wr_mdr_kept", 64'(out), 64'h55);

        // Data and fetch pending together, data acks first
        mir = mk(9'h0, J_NONE, 2'b00, ALU_ZERO, C_NONE, M_RD | M_FETCH, 4'd0);
        tick();
        chk("dual_dreq", 64'(dmem_req), 64'h1);
        chk("dual_ireq", 64'(imem_req), 64'h1);
        mir        = mk(9'h0, J_NONE, 2'b00, ALU_A1, C_H, M_NONE, 4'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234;
        #1 chk("dual_stall1", 64'(stall), 64'h1);
        tick();
        dmem_ack = 1'b0;
        #1 chk("dual_stall2", 64'(stall), 64'h1);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 8'hF0;
        #1 chk("dual_stall3", 64'(stall), 64'h0);
        tick();
        imem_ack = 1'b0;
        chk("dual_k1_once", 64'(out), 64'h56);
        mir = mk(9'h0, J_NONE, 2'b00, ALU_B, C_H, M_NONE, B_MDR);
        tick();
        chk("dual_mdr", 64'(out), 64'h1234);
        mir = mk(9'h0, J_NONE, 2'b00, ALU_B, C_H, M_NONE, B_MBS);
        tick();
        chk("mbr_sext", 64'(out), 64'hFFFF_FFF0);
        mir = mk(9'h0, J_NONE, 2'b00, ALU_B, C_H, M_NONE, B_MBZ);
        tick();
        chk("mbr_zext", 64'(out), 64'hF0);

        // Reset while a read is outstanding, then a late ack
        mir = mk(9'h0, J_NONE, 2'b00, ALU_ZERO, C_NONE, M_RD, 4'd0);
        tick();
        chk("mid_req", 64'(dmem_req), 64'h1);
        mir = NOP;
        #2 reset = 1'b1;
        #1 chk("mid_req_drop", 64'(dmem_req), 64'h0);
        chk("mid_stall_cnt", 64'(stall_cnt), 64'h0);
        chk("mid_cyc_cnt", 64'(cyc_cnt), 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h77;
        #1 chk("late_ack_stall", 64'(stall), 64'h0);
        tick();
        dmem_ack = 1'b0;
        mir = mk(9'h0, J_NONE, 2'b00, ALU_B, C_H, M_NONE, B_MDR);
        tick();
        chk("late_ack_mdr", 64'(out), 64'h0);
        chk("late_ack_req", 64'(dmem_req), 64'h0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
